// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter
//   Shares the core's single memory port between instruction fetch (IFU) and
//   the load/store unit (LSU). At most one transaction is outstanding. The LSU
//   has fixed priority. The IFU is forced to win after STARVE_MAX consecutive
//   LSU grants that it spent waiting. A response is routed back to the
//   requester that owns the transaction. Fetch responses that are in flight
//   during a pipeline flush are dropped.
//
// Ports
//   clk, rst_n       core clock, asynchronous active-low reset
//   flush            pipeline flush; kills an in-flight fetch response
//   ifu_req_*        fetch request (valid/ready/addr)
//   ifu_rsp_*        fetch response (one-cycle valid pulse, data)
//   lsu_req_*        LSU request (valid/ready/addr/wen/wdata/wmask)
//   lsu_rsp_*        LSU completion (one-cycle valid pulse, load data)
//   mem_req_*        memory request (valid/ready/addr/wen/wdata/wmask)
//   mem_rsp_*        memory response (valid, read data)
//
// state | meaning
// IDLE  | no transaction; arbitrate and accept one request
// REQ   | request presented to memory, waiting for mem_req_ready
// WAIT  | request accepted by memory, waiting for mem_rsp_valid
module core_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_rsp_valid,
  output logic [DATA_W-1:0] ifu_rsp_data,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [7:0]        lsu_req_wmask,
  output logic              lsu_rsp_valid,
  output logic [DATA_W-1:0] lsu_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state, state_nxt;
  logic       owner_lsu;   // 0 = IFU owns the transaction, 1 = LSU
  logic       drop;
  logic [3:0] starve_cnt;
  logic       ifu_win;
  logic       ifu_acc;
  logic       lsu_acc;
  logic       rsp_done;

  // The IFU only beats a valid LSU request once the starve count has saturated.
  assign ifu_win  = ifu_req_valid && (!lsu_req_valid || (starve_cnt == STARVE_LIM));
  assign ifu_acc  = ifu_req_ready;
  assign lsu_acc  = lsu_req_ready;
  assign rsp_done = (state == WAIT) && mem_rsp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        if (ifu_win) begin
          ifu_req_ready = 1'b1;
          state_nxt     = REQ;
        end else if (lsu_req_valid) begin
          lsu_req_ready = 1'b1;
          state_nxt     = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request registers: loaded only on acceptance, so they stay stable in REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      owner_lsu     <= 1'b0;
    end else if (ifu_acc) begin
      mem_req_addr  <= ifu_req_addr;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      owner_lsu     <= 1'b0;
    end else if (lsu_acc) begin
      mem_req_addr  <= lsu_req_addr;
      mem_req_wen   <= lsu_req_wen;
      mem_req_wdata <= lsu_req_wdata;
      mem_req_wmask <= lsu_req_wmask;
      owner_lsu     <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (ifu_acc) begin
      starve_cnt <= '0;
    end else if (lsu_acc && ifu_req_valid && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop <= 1'b0;
    end else if (rsp_done) begin
      drop <= 1'b0;
    end else if (flush && ((!owner_lsu && (state != IDLE)) || ifu_acc)) begin
      drop <= 1'b1;
    end
  end

  // A flush in the very cycle the fetch data returns also kills that response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      ifu_rsp_data  <= '0;
      lsu_rsp_data  <= '0;
    end else begin
      ifu_rsp_valid <= rsp_done && !owner_lsu && !drop && !flush;
      lsu_rsp_valid <= rsp_done && owner_lsu;
      if (rsp_done && !owner_lsu && !drop && !flush) ifu_rsp_data <= mem_rsp_data;
      if (rsp_done && owner_lsu)                     lsu_rsp_data <= mem_rsp_data;
    end
  end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares the core's single memory port between instruction fetch (IFU) and the EX-stage load/store unit (LSU).
- Allows one outstanding transaction at a time.
- LSU has fixed priority, with a starvation guard for IFU.
- Routes each response back to the requester that owns the transaction.
- Drops stale fetch responses after a pipeline flush.

Parameters:
ADDR_W, 32, request address width
DATA_W, 64, data width (CORE_XLEN)
STARVE_MAX, 4, consecutive LSU grants with IFU waiting before IFU is forced to win (1..15)

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  pipeline flush (from EX commit); kills in-flight fetch response
ifu_req_valid  in  1  fetch request valid
ifu_req_ready  out  1  fetch request accepted
ifu_req_addr  in  ADDR_W  fetch address
ifu_rsp_valid  out  1  fetch data valid, one-cycle pulse
ifu_rsp_data  out  DATA_W  fetch read data
lsu_req_valid  in  1  LSU request valid
lsu_req_ready  out  1  LSU request accepted
lsu_req_addr  in  ADDR_W  LSU address
lsu_req_wen  in  1  1 = store, 0 = load
lsu_req_wdata  in  DATA_W  store data
lsu_req_wmask  in  8  store byte mask
lsu_rsp_valid  out  1  LSU completion pulse (load data or store ack)
lsu_rsp_data  out  DATA_W  load data
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  memory address
mem_req_wen  out  1  memory write enable
mem_req_wdata  out  DATA_W  memory write data
mem_req_wmask  out  8  memory byte mask
mem_rsp_valid  in  1  memory response valid
mem_rsp_data  in  DATA_W  memory read data

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- Reset values:
  - All outputs 0; state IDLE; owner IFU; drop flag 0; starve count 0.
  - Reset asserted mid-transaction abandons the transaction. No response is produced after reset release.
- State machine: IDLE -> REQ -> WAIT -> IDLE.
- IDLE:
  - Grant rule: LSU wins if lsu_req_valid, unless starve count == STARVE_MAX and ifu_req_valid, in which case IFU wins. Otherwise IFU wins if ifu_req_valid.
  - lsu_req_ready / ifu_req_ready are combinational: asserted only in IDLE, only for the granted requester, at most one per cycle. Both are 0 outside IDLE.
  - On acceptance: latch addr, wen, wdata and wmask into the mem_req_* registers. IFU requests latch wen=0, wmask=0. Latch owner; go to REQ.
- REQ:
  - mem_req_valid=1 from the cycle after acceptance.
  - mem_req_* stay stable until mem_req_ready. On handshake, go to WAIT.
  - A request is never withdrawn once mem_req_valid is asserted.
- WAIT:
  - On mem_rsp_valid, go to IDLE.
  - The next cycle, pulse the owner's rsp_valid for exactly one cycle, with rsp_data = registered mem_rsp_data.
  - Minimum accept-to-response latency is 3 cycles (mem_req_ready and mem_rsp_valid each 1 cycle).
- New-grant timing: a new grant is possible in the same cycle the previous rsp_valid pulses (state is already IDLE).
- mem_rsp_valid outside WAIT is ignored; no state change.
- Starve count:
  - +1 (saturating at STARVE_MAX) on each LSU acceptance while ifu_req_valid=1.
  - Cleared on IFU acceptance.
  - Unchanged otherwise.
- Flush:
  - Sets the drop flag if owner=IFU and state is REQ or WAIT, or if an IFU acceptance happens in the same cycle as flush.
  - With drop=1, the memory transaction still completes, but ifu_rsp_valid stays 0. Drop clears on returning to IDLE.
  - Flush never affects LSU transactions, the LSU response, or the starve count.
- Inactive response data: rsp_data of the non-owner holds its previous value; rsp_valid=0.

Test Plan:
- Single LSU load to 0x80, mem_req_ready and mem_rsp_valid 1 cycle after each, data 0x1122334455667788 -> mem_req_valid cycle 1, lsu_rsp_valid pulse cycle 3 with that data; ifu_rsp_valid never asserted.
- IFU and LSU both valid every cycle, STARVE_MAX=4 -> grant order L,L,L,L,I,L,L,L,L,I; only one *_req_ready high per cycle.
- Store addr 0x100, wdata 0xA5, wmask 0x01, mem_req_ready held low 5 cycles -> mem_req_* stable and mem_req_valid high all 6 cycles, lsu_req_ready low throughout.
- IFU fetch 0x2000, flush pulsed in WAIT -> memory response consumed, ifu_rsp_valid stays 0, next IFU fetch 0x3000 returns normally.
- Flush in same cycle as IFU acceptance -> response dropped; flush during LSU transaction -> lsu_rsp_valid still pulses.
- rst_n low while in WAIT, then released, late mem_rsp_valid -> no rsp pulses, state IDLE, outputs 0.
